// File: rtl/dec4b3b.sv
// 4B/3B sub-block decoder: fghj nibble plus K.28/rd context -> HGF, K flag,
// code and disparity violations, running disparity after the 4b sub-block.
// Latency 2 falling edges, one symbol per cycle, no backpressure.
// Optional saturating error counter enabled by defining ERRCNT_EN.
module dec4b3b #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [3:0]           sub4,
  input  logic                 k28,
  input  logic                 rd6,
  input  logic                 err_clr,
  output logic                 out_valid,
  output logic [2:0]           data_out,
  output logic                 k_out,
  output logic                 code_err,
  output logic                 disp_err,
  output logic                 rd_out,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // stage-1 capture registers
  logic       v1_q;
  logic [3:0] sub4_q;
  logic       k28_q;
  logic       rd6_q;

  // stage-2 output registers
  logic       ov_q;
  logic [2:0] data_q;
  logic       k_q;
  logic       ce_q;
  logic       de_q;
  logic       rd_q;

  // decode of the captured symbol
  logic [3:0] n_d;
  logic [2:0] hgf_d;
  logic       ce_d;
  logic       de_d;
  logic       rd_d;
  logic       k_d;
  logic [2:0] pop_d;

  // Stage 1: capture the nibble and its context when qualified, else hold.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      sub4_q <= 4'b0000;
      k28_q  <= 1'b0;
      rd6_q  <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        sub4_q <= sub4;
        k28_q  <= k28;
        rd6_q  <= rd6;
      end
    end
  end

  // Decode: K28 at negative disparity arrives inverted, so undo that before
  // the lookup; disparity is always judged on the raw received bits.
  always_comb begin
    n_d   = (k28_q && !rd6_q) ? ~sub4_q : sub4_q;
    hgf_d = 3'b111;
    ce_d  = 1'b0;
    case (n_d)
      4'b1011, 4'b0100:                   hgf_d = 3'b000;
      4'b1001:                            hgf_d = 3'b001;
      4'b0101:                            hgf_d = 3'b010;
      4'b1100, 4'b0011:                   hgf_d = 3'b011;
      4'b1101, 4'b0010:                   hgf_d = 3'b100;
      4'b1010:                            hgf_d = 3'b101;
      4'b0110:                            hgf_d = 3'b110;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: hgf_d = 3'b111;
      default: begin
        hgf_d = 3'b111;
        ce_d  = 1'b1;
      end
    endcase
    pop_d = 3'(sub4_q[3]) + 3'(sub4_q[2]) + 3'(sub4_q[1]) + 3'(sub4_q[0]);
    de_d  = !ce_d && (((pop_d == 3'd3) && rd6_q) || ((pop_d == 3'd1) && !rd6_q));
    // Running disparity follows the code even on a violation (resync);
    // illegal codes leave it untouched.
    if (ce_d)                 rd_d = rd_q;
    else if (pop_d == 3'd3)   rd_d = 1'b1;
    else if (pop_d == 3'd1)   rd_d = 1'b0;
    else                      rd_d = rd6_q;
    k_d = k28_q && !ce_d;
  end

  // Stage 2: register decoded outputs; flags drop to 0 in bubbles, data and
  // running disparity persist.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ov_q   <= 1'b0;
      data_q <= 3'b000;
      k_q    <= 1'b0;
      ce_q   <= 1'b0;
      de_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      ov_q <= v1_q;
      if (v1_q) begin
        data_q <= hgf_d;
        k_q    <= k_d;
        ce_q   <= ce_d;
        de_q   <= de_d;
        rd_q   <= rd_d;
      end else begin
        k_q  <= 1'b0;
        ce_q <= 1'b0;
        de_q <= 1'b0;
      end
    end
  end

  assign out_valid = ov_q;
  assign data_out  = data_q;
  assign k_out     = k_q;
  assign code_err  = ce_q;
  assign disp_err  = de_q;
  assign rd_out    = rd_q;

`ifdef ERRCNT_EN
  logic [ERR_CNT_W-1:0] cnt_q;
  logic [ERR_CNT_W-1:0] cnt_d;

  // Counter next state: clear wins, otherwise count erroring outputs up to all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)
      cnt_d = '0;
    else if (v1_q && (ce_d || de_d) && (cnt_q != {ERR_CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register, updated on the same edge as the outputs it counts.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_cnt = cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: doc/dec4b3b.md
Name: dec4b3b

Overview:
- 4B/3B sub-block decoder for the 10B/8B decoder path; receive-side counterpart of the encoder's 3B/4B classification stage.
- Accepts the fghj nibble of a received symbol with context from the 6B/5B stage: K.28 flag and running disparity entering the 4b sub-block.
- Recovers HGF and flags invalid-code and disparity violations.
- Two-stage registered pipeline with valid qualifier.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter (used only with ERRCNT_EN).

Ports:
- clk  input  1  clock; all registers update on falling edge, same as encoder stages.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  qualifies sub4, k28, rd6 this cycle.
- sub4  input  4  received nibble {f,g,h,j}; sub4[3]=f (first transmitted) ... sub4[0]=j.
- k28  input  1  6B stage decoded abcdei as K.28 (001111 or 110000).
- rd6  input  1  running disparity entering the 4b sub-block; 1 = positive, 0 = negative.
- err_clr  input  1  synchronous clear of err_cnt.
- out_valid  output  1  qualifies outputs.
- data_out  output  3  decoded {H,G,F}.
- k_out  output  1  symbol is K28.y.
- code_err  output  1  illegal nibble.
- disp_err  output  1  nibble disparity contradicts rd6.
- rd_out  output  1  running disparity after the 4b sub-block (registered, persistent).
- err_cnt  output  ERR_CNT_W  saturating error count.

Behaviour:
- Reset (async, immediate): out_valid=0, data_out=000, k_out=0, code_err=0, disp_err=0, rd_out=0 (negative), err_cnt=0, all stage-1 registers 0.
- Stage 1, falling edge:
  - v1 <= in_valid.
  - If in_valid, capture sub4, k28, rd6.
  - Otherwise hold the captured data.
- Stage 2, falling edge:
  - out_valid <= v1.
  - If v1, decode the captured data into outputs.
  - Otherwise hold outputs, except code_err, disp_err and k_out, which are 0 whenever out_valid=0.
- Latency: in_valid sampled at falling edge N gives out_valid=1 after falling edge N+2. One symbol per cycle, no stall, no backpressure.
- Pre-map: n = ~sub4 if (k28 && rd6==0), else n = sub4. This corrects the K28.1/.2/.5/.6 inversion.
- Lookup on n gives HGF:
  - 1011/0100 -> 000
  - 1001 -> 001
  - 0101 -> 010
  - 1100/0011 -> 011
  - 1101/0010 -> 100
  - 1010 -> 101
  - 0110 -> 110
  - 1110/0001/0111/1000 -> 111
- Illegal nibbles 0000 and 1111: code_err=1, data_out=111, disp_err=0, rd_out unchanged.
- k_out = captured k28 && !code_err.
- Disparity, on raw sub4 (not the pre-map):
  - Popcount 3 is +2; popcount 1 is -2; popcount 2 is neutral.
  - disp_err=1 if +2 with rd6=1, or -2 with rd6=0.
  - rd_out <= 1 after +2, 0 after -2, rd6 after neutral.
  - rd_out follows the code even when disp_err=1 (resync).
- Simultaneous code_err and disp_err cannot occur: illegal codes suppress disp_err.
- Reset mid-stream drops all in-flight symbols; first output after release needs two valid edges.

Optional Feature:
- ERRCNT_EN defined:
  - err_cnt increments by 1 on each output cycle with (code_err|disp_err).
  - Saturates at all-ones.
  - err_clr has priority over increment and sets err_cnt to 0 on the next falling edge.
- ERRCNT_EN undefined: no counter logic; err_cnt tied to 0; err_clr ignored.

Test Plan:
- Reset then D.x.0..D.x.7 nibbles {1011,1001,0101,1100,1101,1010,0110,1110} with k28=0, rd6=0, back-to-back -> data_out 000..111 on consecutive cycles, first at edge N+2, no errors.
- K28.5 both polarities: (sub4=1010,k28=1,rd6=1) and (sub4=0101,k28=1,rd6=0) -> data_out=101, k_out=1, errors 0. K28.1: (0110,k28=1,rd6=0) -> 001.
- Disparity: sub4=1110 with rd6=1 -> disp_err=1, data_out=111, rd_out=1. sub4=0100 with rd6=0 -> disp_err=1, rd_out=0. sub4=0101 with rd6=1 -> no error, rd_out=1.
- Illegal: sub4=0000 then 1111 -> code_err=1 both cycles, k_out=0, rd_out unchanged from prior value.
- Bubbles/reset: in_valid pattern 1,0,1 -> out_valid 1,0,1 delayed 2 cycles, error flags 0 in gap. Assert rst mid-stream -> outputs clear immediately, no stale out_valid after release.
- ERRCNT_EN, ERR_CNT_W=2: 5 consecutive illegal nibbles -> err_cnt 1,2,3,3,3. err_clr concurrent with an error -> 0.
